launch_turn_scheduler: RTL and testbench

//  Sits between the two per-player keyboard command paths (velocity/angle/fire from each line interpreter)
//  and the single shared missile-flight engine. Buffers one pending shot per player, enforces strict

---
 rtl/launch_turn_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_launch_turn_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/launch_turn_scheduler.sv
// launch_turn_scheduler: buffers one shot per player, issues shots to the shared
// flight engine in strict turn order, then waits for flight end and a cooldown.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for the slot of the player whose turn it is
// ST_ISSUE    | launch_valid high, launch_* held until launch_ready
// ST_FLIGHT   | engine busy; ends on flight_done or on timeout
// ST_COOLDOWN | fixed idle gap, then turn hands over to the other player
module launch_turn_scheduler #(
  parameter int DATA_W          = 32,
  parameter int MAX_ANGLE       = 90,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              p0_fire,
  input  logic [DATA_W-1:0] p0_velocity,
  input  logic [DATA_W-1:0] p0_angle,
  input  logic              p1_fire,
  input  logic [DATA_W-1:0] p1_velocity,
  input  logic [DATA_W-1:0] p1_angle,
  output logic              launch_valid,
  input  logic              launch_ready,
  output logic              launch_player,
  output logic [DATA_W-1:0] launch_velocity,
  output logic [DATA_W-1:0] launch_angle,
  input  logic              flight_done,
  output logic              turn,
  output logic              p0_pending,
  output logic              p1_pending,
  output logic [1:0]        drop_pulse,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FLIGHT,
    ST_COOLDOWN
  } state_t;

  // One down-counter is shared by FLIGHT and COOLDOWN; it is sized for the longer.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > COOLDOWN_CYCLES) ? TIMEOUT_CYCLES : COOLDOWN_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]  TMO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [DATA_W-1:0] MAX_A     = DATA_W'(MAX_ANGLE);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              cnt_tc;
  logic              handshake;
  logic              load_launch;
  logic              tmo_hit;
  logic              turn_flip;

  logic [1:0]        fire;
  logic [DATA_W-1:0] in_vel [2];
  logic [DATA_W-1:0] in_ang [2];
  logic [1:0]        slot_full;
  logic [DATA_W-1:0] slot_vel [2];
  logic [DATA_W-1:0] slot_ang [2];

  function automatic logic [DATA_W-1:0] clamp_angle(input logic [DATA_W-1:0] a);
    return (a > MAX_A) ? MAX_A : a;
  endfunction

  assign fire      = {p1_fire, p0_fire};
  assign in_vel[0] = p0_velocity;
  assign in_vel[1] = p1_velocity;
  assign in_ang[0] = p0_angle;
  assign in_ang[1] = p1_angle;

  assign cnt_tc       = (cnt == '0);
  assign launch_valid = (state == ST_ISSUE);
  assign p0_pending   = slot_full[0];
  assign p1_pending   = slot_full[1];

  // State register and shared down-counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state, counter reload/decrement and control strobes.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    handshake   = 1'b0;
    load_launch = 1'b0;
    tmo_hit     = 1'b0;
    turn_flip   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (slot_full[turn]) begin
          state_nx    = ST_ISSUE;
          load_launch = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (launch_ready) begin
          handshake = 1'b1;
          state_nx  = ST_FLIGHT;
          cnt_nx    = TMO_LOAD;
        end
      end
      ST_FLIGHT: begin
        // A done arriving on the terminal cycle still counts as a normal finish.
        if (flight_done) begin
          state_nx = ST_COOLDOWN;
          cnt_nx   = COOL_LOAD;
        end else if (cnt_tc) begin
          state_nx = ST_COOLDOWN;
          cnt_nx   = COOL_LOAD;
          tmo_hit  = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_tc) begin
          state_nx  = ST_IDLE;
          turn_flip = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Per-player shot slots: capture when empty, drop when full, free on handshake.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      slot_full  <= '0;
      drop_pulse <= '0;
      for (int n = 0; n < 2; n++) begin
        slot_vel[n] <= '0;
        slot_ang[n] <= '0;
      end
    end else begin
      drop_pulse <= '0;
      for (int n = 0; n < 2; n++) begin
        if (fire[n]) begin
          if (slot_full[n]) begin
            drop_pulse[n] <= 1'b1;
          end else begin
            slot_full[n] <= 1'b1;
            slot_vel[n]  <= in_vel[n];
            slot_ang[n]  <= clamp_angle(in_ang[n]);
          end
        end
        if (handshake && (turn == 1'(n))) begin
          slot_full[n] <= 1'b0;
        end
      end
    end
  end

  // Launch payload, turn ownership and timeout strobe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      launch_player   <= 1'b0;
      launch_velocity <= '0;
      launch_angle    <= '0;
      turn            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;
      if (load_launch) begin
        launch_player   <= turn;
        launch_velocity <= slot_vel[turn];
        launch_angle    <= slot_ang[turn];
      end
      if (turn_flip) begin
        turn <= ~turn;
      end
    end
  end

endmodule

// File: tb/tb_launch_turn_scheduler.sv
// Testbench for launch_turn_scheduler: scoreboard of expected shots per player,
// popped and compared whenever the engine handshake fires.
module tb_launch_turn_scheduler;

  localparam int DW = 32;

  logic          clock;
  logic          resetn;
  logic          p0_fire, p1_fire;
  logic [DW-1:0] p0_velocity, p0_angle, p1_velocity, p1_angle;
  logic          launch_valid, launch_ready, launch_player;
  logic [DW-1:0] launch_velocity, launch_angle;
  logic          flight_done;
  logic          turn, p0_pending, p1_pending, timeout_err;
  logic [1:0]    drop_pulse;

  typedef struct packed {
    logic [DW-1:0] v;
    logic [DW-1:0] a;
  } shot_t;

  shot_t exp_q0[$];
  shot_t exp_q1[$];
  shot_t mon_e;
  logic  mon_found;
  logic  exp_turn;
  int    checks = 0;
  int    errors = 0;

  launch_turn_scheduler #(
    .DATA_W(DW), .MAX_ANGLE(90), .COOLDOWN_CYCLES(16), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clock(clock), .resetn(resetn),
    .p0_fire(p0_fire), .p0_velocity(p0_velocity), .p0_angle(p0_angle),
    .p1_fire(p1_fire), .p1_velocity(p1_velocity), .p1_angle(p1_angle),
    .launch_valid(launch_valid), .launch_ready(launch_ready),
    .launch_player(launch_player), .launch_velocity(launch_velocity),
    .launch_angle(launch_angle), .flight_done(flight_done), .turn(turn),
    .p0_pending(p0_pending), .p1_pending(p1_pending),
    .drop_pulse(drop_pulse), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: every handshake must match the next expected shot of the expected player.
  always @(negedge clock) begin
    if (resetn && launch_valid && launch_ready) begin
      checks++;
      if (launch_player !== exp_turn) begin
        errors++;
        $display("FAIL handshake_player got %0d want %0d", launch_player, exp_turn);
      end
      mon_found = 1'b0;
      if (exp_turn == 1'b0) begin
        if (exp_q0.size() > 0) begin mon_e = exp_q0.pop_front(); mon_found = 1'b1; end
      end else begin
        if (exp_q1.size() > 0) begin mon_e = exp_q1.pop_front(); mon_found = 1'b1; end
      end
      checks++;
      if (!mon_found) begin
        errors++;
        $display("FAIL handshake_unexpected got v=%0d a=%0d want no shot", launch_velocity, launch_angle);
      end else if (launch_velocity !== mon_e.v || launch_angle !== mon_e.a) begin
        errors++;
        $display("FAIL handshake_payload got v=%0d a=%0d want v=%0d a=%0d",
                 launch_velocity, launch_angle, mon_e.v, mon_e.a);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push_shot(input logic p, input logic [DW-1:0] v, input logic [DW-1:0] a);
    shot_t s;
    s.v = v;
    s.a = a;
    if (p == 1'b0) exp_q0.push_back(s);
    else           exp_q1.push_back(s);
  endtask

  task automatic fire0(input logic [DW-1:0] v, input logic [DW-1:0] a);
    p0_fire = 1'b1; p0_velocity = v; p0_angle = a;
  endtask

  task automatic fire1(input logic [DW-1:0] v, input logic [DW-1:0] a);
    p1_fire = 1'b1; p1_velocity = v; p1_angle = a;
  endtask

  // Called just after the edge that enters COOLDOWN.
  task automatic check_cooldown();
    logic old_turn;
    old_turn = exp_turn;
    cyc();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL cooldown_tmo_clear got %0d want 0", timeout_err);
    end
    repeat (14) cyc();
    checks++;
    if (turn !== old_turn) begin
      errors++;
      $display("FAIL cooldown_turn_hold got %0d want %0d", turn, old_turn);
    end
    cyc();
    checks++;
    if (turn !== ~old_turn) begin
      errors++;
      $display("FAIL cooldown_turn_toggle got %0d want %0d", turn, ~old_turn);
    end
    exp_turn = ~old_turn;
  endtask

  task automatic finish_flight();
    repeat (3) cyc();
    flight_done = 1'b1;
    cyc();
    flight_done = 1'b0;
    check_cooldown();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    p0_fire = 0; p1_fire = 0; p0_velocity = '0; p0_angle = '0;
    p1_velocity = '0; p1_angle = '0; launch_ready = 1'b1; flight_done = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    exp_turn = 1'b0;
    repeat (2) cyc();
    checks++;
    if ({launch_valid, launch_player, launch_velocity, launch_angle, turn,
         p0_pending, p1_pending, drop_pulse, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%0d player=%0d v=%0d a=%0d turn=%0d pend=%0d%0d drop=%0d tmo=%0d want all 0",
               launch_valid, launch_player, launch_velocity, launch_angle, turn,
               p1_pending, p0_pending, drop_pulse, timeout_err);
    end
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_basic_issue();
    launch_ready = 1'b1;
    fire0(40, 30);
    push_shot(0, 40, 30);
    cyc();
    p0_fire = 1'b0;
    checks++;
    if (p0_pending !== 1'b1 || launch_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_capture got pend=%0d valid=%0d want 1 0", p0_pending, launch_valid);
    end
    cyc();
    checks++;
    if (launch_valid !== 1'b1 || launch_player !== 1'b0 || launch_velocity !== 40 || launch_angle !== 30) begin
      errors++;
      $display("FAIL basic_latency got valid=%0d p=%0d v=%0d a=%0d want 1 0 40 30",
               launch_valid, launch_player, launch_velocity, launch_angle);
    end
    cyc();
    checks++;
    if (launch_valid !== 1'b0 || p0_pending !== 1'b0) begin
      errors++;
      $display("FAIL basic_handshake_1cyc got valid=%0d pend=%0d want 0 0", launch_valid, p0_pending);
    end
    finish_flight();
  endtask

  task automatic test_alternation_clamp();
    test_reset();
    fire1(77, 120);
    push_shot(1, 77, 90);
    cyc();
    p1_fire = 1'b0;
    checks++;
    if (p1_pending !== 1'b1) begin
      errors++;
      $display("FAIL alt_p1_pending got %0d want 1", p1_pending);
    end
    repeat (3) begin
      cyc();
      checks++;
      if (launch_valid !== 1'b0) begin
        errors++;
        $display("FAIL alt_out_of_turn got valid=%0d want 0", launch_valid);
      end
    end
    fire0(5, 10);
    push_shot(0, 5, 10);
    cyc();
    p0_fire = 1'b0;
    cyc();
    cyc();
    finish_flight();
    cyc();
    checks++;
    if (launch_valid !== 1'b1 || launch_player !== 1'b1 || launch_angle !== 90) begin
      errors++;
      $display("FAIL alt_p1_issue got valid=%0d p=%0d a=%0d want 1 1 90",
               launch_valid, launch_player, launch_angle);
    end
    cyc();
    finish_flight();
  endtask

  task automatic test_drop();
    launch_ready = 1'b0;
    fire0(11, 22);
    push_shot(0, 11, 22);
    cyc();
    p0_fire = 1'b0;
    cyc();
    fire0(99, 45);
    cyc();
    p0_fire = 1'b0;
    checks++;
    if (drop_pulse !== 2'b01) begin
      errors++;
      $display("FAIL drop_pulse got %b want 01", drop_pulse);
    end
    checks++;
    if (launch_valid !== 1'b1 || launch_velocity !== 11 || launch_angle !== 22) begin
      errors++;
      $display("FAIL drop_slot_kept got valid=%0d v=%0d a=%0d want 1 11 22",
               launch_valid, launch_velocity, launch_angle);
    end
    cyc();
    checks++;
    if (drop_pulse !== 2'b00) begin
      errors++;
      $display("FAIL drop_one_cycle got %b want 00", drop_pulse);
    end
    launch_ready = 1'b1;
    fire0(33, 33);
    cyc();
    p0_fire = 1'b0;
    checks++;
    if (drop_pulse !== 2'b01 || p0_pending !== 1'b0 || launch_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_same_cycle_handshake got drop=%b pend=%0d valid=%0d want 01 0 0",
               drop_pulse, p0_pending, launch_valid);
    end
    finish_flight();
  endtask

  task automatic test_backpressure();
    launch_ready = 1'b0;
    fire1(1000, 90);
    push_shot(1, 1000, 90);
    cyc();
    p1_fire = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (launch_valid !== 1'b1 || launch_player !== 1'b1 || launch_velocity !== 1000 || launch_angle !== 90) begin
        errors++;
        $display("FAIL bp_stable cycle %0d got valid=%0d p=%0d v=%0d a=%0d want 1 1 1000 90",
                 i, launch_valid, launch_player, launch_velocity, launch_angle);
      end
    end
    launch_ready = 1'b1;
    cyc();
    checks++;
    if (launch_valid !== 1'b0 || p1_pending !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got valid=%0d pend=%0d want 0 0", launch_valid, p1_pending);
    end
    finish_flight();
  endtask

  task automatic test_timeout();
    int early;
    launch_ready = 1'b1;
    fire0(0, 91);
    push_shot(0, 0, 90);
    cyc();
    p0_fire = 1'b0;
    cyc();
    checks++;
    if (launch_valid !== 1'b1) begin
      errors++;
      $display("FAIL tmo_zero_vel_issue got valid=%0d want 1", launch_valid);
    end
    cyc();
    early = 0;
    for (int i = 0; i < 4095; i++) begin
      cyc();
      if (timeout_err !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL tmo_early got %0d pulses want 0", early);
    end
    cyc();
    checks++;
    if (timeout_err !== 1'b1 || turn !== exp_turn) begin
      errors++;
      $display("FAIL tmo_pulse got tmo=%0d turn=%0d want 1 %0d", timeout_err, turn, exp_turn);
    end
    check_cooldown();
  endtask

  task automatic test_reset_in_flight();
    int bad;
    test_reset();
    fire0(50, 50);
    push_shot(0, 50, 50);
    cyc();
    p0_fire = 1'b0;
    cyc();
    cyc();
    fire1(3, 3);
    cyc();
    p1_fire = 1'b0;
    checks++;
    if (p1_pending !== 1'b1) begin
      errors++;
      $display("FAIL rif_p1_pending got %0d want 1", p1_pending);
    end
    cyc();
    resetn = 1'b0;
    #2;
    checks++;
    if ({launch_valid, launch_player, launch_velocity, launch_angle, turn,
         p0_pending, p1_pending, drop_pulse, timeout_err} !== '0) begin
      errors++;
      $display("FAIL rif_async_clear got valid=%0d v=%0d a=%0d turn=%0d pend=%0d%0d want all 0",
               launch_valid, launch_velocity, launch_angle, turn, p1_pending, p0_pending);
    end
    exp_q0.delete();
    exp_q1.delete();
    exp_turn = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
    flight_done = 1'b1;
    cyc();
    flight_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (turn !== 1'b0 || launch_valid !== 1'b0 || p0_pending !== 1'b0 ||
          p1_pending !== 1'b0 || timeout_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rif_late_done got %0d disturbed cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_alternation_clamp();
    test_drop();
    test_backpressure();
    test_timeout();
    test_reset_in_flight();
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d/%0d shots want 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
